// File: rtl/board_loader_if.sv
// Engine-side handshake bundle for board_loader.
//   pattern  : committed board image (bit k = cell k), stable while load_req=1
//   load_req : committed image waiting for the engine
//   load_ack : engine has copied pattern
// master = loader side, slave = engine side.
interface board_loader_if #(
  parameter int CELLS = 64
);
  logic [CELLS-1:0] pattern;
  logic             load_req;
  logic             load_ack;

  modport master (output pattern, output load_req, input load_ack);
  modport slave  (input pattern, input load_req, output load_ack);
endinterface

// File: rtl/board_loader.sv
// board_loader: upstream feeder for the Game of Life engine.
// Captures a CELLS-bit board image from a 3-wire serial port or a 4-entry
// preset ROM, commits it on a frame boundary and offers it to the engine
// through a req/ack handshake.
// Ports:
//   clk, reset         pixel clock, synchronous active-high reset
//   spi_sclk/mosi/cs_n async serial port (data sampled on sclk rise)
//   preset_sel, preset_go  load ROM[preset_sel] on a 1-cycle go pulse
//   frame_start        1-cycle pulse at start of vertical blank
//   eng                handshake bundle (pattern, load_req, load_ack)
//   busy               FSM not idle
//   overrun            sticky: serial frame dropped or malformed
module board_loader #(
  parameter int CELLS       = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_sclk,
  input  logic                  spi_mosi,
  input  logic                  spi_cs_n,
  input  logic [1:0]            preset_sel,
  input  logic                  preset_go,
  input  logic                  frame_start,
  board_loader_if.master        eng,
  output logic                  busy,
  output logic                  overrun
);

  localparam int CW = $clog2(CELLS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, READY, REQ} state_e;

  // Synchronisers. sclk/cs_n carry one extra flop so edges are detected
  // between the last synced stage and its delayed copy.
  logic [SYNC_STAGES:0]   sclk_q;
  logic [SYNC_STAGES:0]   csn_q;
  logic [SYNC_STAGES-1:0] mosi_q;

  logic sclk_rise, csn_fall, csn_rise, mosi_s;

  state_e           state_q;
  logic [CELLS-1:0] shreg_q;
  logic [CELLS-1:0] pattern_q;
  logic [CW-1:0]    count_q;
  logic             load_req_q;
  logic             overrun_q;

  function automatic logic [CELLS-1:0] rom_image(input logic [1:0] sel);
    logic [CELLS-1:0] img;
    case (sel)
      2'd0:    img = CELLS'(64'h50A8_8888_0609_0909);
      2'd1:    img = CELLS'(64'h0000_0000_0007_0402);
      2'd2:    img = CELLS'(64'h0000_0000_3800_0000);
      default: img = '0;
    endcase
    return img;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q <= '0;
      csn_q  <= '1;  // idle-high so leaving reset never fakes a cs_n fall
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-1:0], spi_sclk};
      csn_q  <= {csn_q[SYNC_STAGES-1:0], spi_cs_n};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
  assign csn_fall  = ~csn_q[SYNC_STAGES-1] & csn_q[SYNC_STAGES];
  assign csn_rise  = csn_q[SYNC_STAGES-1] & ~csn_q[SYNC_STAGES];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      pattern_q  <= '0;
      count_q    <= '0;
      load_req_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (csn_fall) begin
            state_q <= SHIFT;
            count_q <= '0;
          end else if (preset_go) begin
            shreg_q <= rom_image(preset_sel);
            state_q <= READY;
          end
        end
        SHIFT: begin
          // A cs_n rise closes the frame before any coincident sclk rise.
          if (csn_rise) begin
            if (count_q == CW'(CELLS)) begin
              state_q <= READY;
            end else begin
              state_q   <= IDLE;
              overrun_q <= 1'b1;
            end
          end else if (sclk_rise && (count_q != CW'(CELLS))) begin
            shreg_q <= {shreg_q[CELLS-2:0], mosi_s};
            count_q <= count_q + CW'(1);
          end
        end
        READY: begin
          if (csn_fall) overrun_q <= 1'b1;
          if (frame_start) begin
            pattern_q  <= shreg_q;
            load_req_q <= 1'b1;
            state_q    <= REQ;
          end
        end
        REQ: begin
          if (csn_fall) overrun_q <= 1'b1;
          if (eng.load_ack) begin
            load_req_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign eng.pattern  = pattern_q;
  assign eng.load_req = load_req_q;
  assign busy         = (state_q != IDLE);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_board_loader.sv
module tb_board_loader;
  localparam int CELLS = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_sclk = 1'b0, spi_mosi = 1'b0, spi_cs_n = 1'b1;
  logic [1:0] preset_sel = '0;
  logic       preset_go = 1'b0, frame_start = 1'b0;
  logic       busy, overrun;

  board_loader_if #(.CELLS(CELLS)) bus();

  board_loader #(.CELLS(CELLS), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .preset_sel(preset_sel), .preset_go(preset_go), .frame_start(frame_start),
    .eng(bus), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Scoreboard: expected committed images, in commit order.
  logic [63:0] exp_q[$];

  // Reference model: where the loaded image sits (nowhere / staged / offered).
  logic        m_staged, m_req, m_ovr;
  logic [63:0] m_img, m_pat;
  logic [63:0] ROM [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".load_req"}, 64'(bus.load_req), 64'(m_req));
    check({tag, ".busy"},     64'(busy),         64'(m_staged || m_req));
    check({tag, ".overrun"},  64'(overrun),      64'(m_ovr));
    check({tag, ".pattern"},  bus.pattern,       m_pat);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    preset_go = 1'b0; frame_start = 1'b0; bus.load_ack = 1'b0;
    tick(3);
    reset = 1'b0;
    m_staged = 1'b0; m_req = 1'b0; m_ovr = 1'b0; m_img = '0; m_pat = '0;
    exp_q.delete();
    tick(1);
    check_state(tag);
  endtask

  task automatic preset(input logic [1:0] sel);
    @(negedge clk);
    preset_sel = sel; preset_go = 1'b1;
    if (!m_staged && !m_req) begin m_img = ROM[sel]; m_staged = 1'b1; end
    @(negedge clk);
    preset_go = 1'b0;
  endtask

  task automatic fstart();
    @(negedge clk);
    frame_start = 1'b1;
    if (m_staged) begin
      m_pat = m_img; m_staged = 1'b0; m_req = 1'b1;
      exp_q.push_back(m_pat);
    end
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic ack();
    @(negedge clk);
    bus.load_ack = 1'b1;
    if (m_req) m_req = 1'b0;
    @(negedge clk);
    bus.load_ack = 1'b0;
  endtask

  // Bits go out MSB first; bits past 64 are random filler.
  task automatic send_bits(input logic [63:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = (i < 64) ? data[63-i] : 1'($urandom);
      tick(3);
      spi_sclk = 1'b1;
      tick(3);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [63:0] data, input int n);
    logic was_idle;
    @(negedge clk);
    was_idle = !m_staged && !m_req;
    spi_cs_n = 1'b0;
    tick(4);
    send_bits(data, n);
    tick(3);
    spi_cs_n = 1'b1;
    tick(6);
    if (was_idle && n >= 64) begin m_img = data; m_staged = 1'b1; end
    else m_ovr = 1'b1;
  endtask

  // Monitor: each new load_req must present the next expected image,
  // and the image must stay put for as long as load_req is held.
  logic        prev_req = 1'b0;
  logic [63:0] held = '0;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      prev_req = 1'b0;
    end else begin
      if (bus.load_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL commit_unexpected: got %h expected no commit (t=%0t)", bus.pattern, $time);
          held = bus.pattern;
        end else begin
          held = exp_q.pop_front();
          check("commit_pattern", bus.pattern, held);
        end
      end else if (bus.load_req) begin
        check("pattern_stable", bus.pattern, held);
      end
      prev_req = bus.load_req;
    end
  end

  initial begin
    ROM[0] = 64'h50A8_8888_0609_0909;
    ROM[1] = 64'h0000_0000_0007_0402;
    ROM[2] = 64'h0000_0000_3800_0000;
    ROM[3] = 64'h0;
    bus.load_ack = 1'b0;

    // T1 reset values
    do_reset("t1_reset");

    // T2 preset glider, late frame_start, ack
    preset(2'd1);
    tick(10);
    fstart();
    check_state("t2_commit");
    check("t2_glider", bus.pattern, 64'h0000_0000_0007_0402);
    ack();
    check_state("t2_after_ack");

    // T3 full serial frame
    frame(64'hDEAD_BEEF_0123_4567, 64);
    check_state("t3_ready");
    fstart();
    check_state("t3_commit");
    ack();

    // T4 short frame
    frame({$urandom, $urandom}, 40);
    check_state("t4_short");

    // T5 frame while load_req=1, then clear preset
    do_reset("t5_reset");
    preset(2'd2);
    fstart();
    frame({$urandom, $urandom}, 64);
    check_state("t5_dropped");
    ack();
    preset(2'd3);
    fstart();
    check_state("t5_clear");
    ack();

    // T6 frame_start coinciding with entry into READY
    @(negedge clk);
    preset_sel = 2'd0; preset_go = 1'b1; frame_start = 1'b1;
    m_img = ROM[0]; m_staged = 1'b1;
    @(negedge clk);
    preset_go = 1'b0; frame_start = 1'b0;
    tick(2);
    check_state("t6_no_commit");
    fstart();
    check_state("t6_commit");
    ack();

    // T6 reset in the middle of a serial frame
    @(negedge clk);
    spi_cs_n = 1'b0;
    tick(4);
    send_bits({$urandom, $urandom}, 20);
    do_reset("t6_mid_shift_reset");
    tick(10);
    check_state("t6_quiet");

    // Randomised operation mix
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: preset(2'($urandom_range(0, 3)));
        1: frame({$urandom, $urandom}, 64 + $urandom_range(0, 3));
        2: frame({$urandom, $urandom}, $urandom_range(1, 63));
        3: fstart();
        4: ack();
        default: tick($urandom_range(1, 5));
      endcase
      tick(1);
      check_state("rand");
    end

    tick(3);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
